// File: rtl/sprite_mover.sv
// Moves a SPR_W x SPR_H sprite around a VGA frame buffer: erase at the old
// position, update, redraw at the new one, one pixel write per clock.
module sprite_mover #(
  parameter int         SPR_W     = 2,
  parameter int         SPR_H     = 3,
  parameter int         X_BITS    = 8,
  parameter int         Y_BITS    = 7,
  parameter int         STEP      = 1,
  parameter int         X_MIN     = 0,
  parameter int         X_MAX     = 158,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 117,
  parameter int         X_INIT    = 0,
  parameter int         Y_INIT    = 58,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p_up,
  input  logic              p_down,
  input  logic              p_left,
  input  logic              p_right,
  output logic [X_BITS-1:0] x_out,
  output logic [Y_BITS-1:0] y_out,
  output logic [2:0]        colour,
  output logic              write_en,
  output logic [X_BITS-1:0] pos_x,
  output logic [Y_BITS-1:0] pos_y,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(SPR_W + 1);
  localparam int RW = $clog2(SPR_H + 1);

  localparam logic [X_BITS:0] STEP_XE  = (X_BITS + 1)'(STEP);
  localparam logic [X_BITS:0] X_MIN_E  = (X_BITS + 1)'(X_MIN);
  localparam logic [X_BITS:0] X_MAX_E  = (X_BITS + 1)'(X_MAX);
  localparam logic [Y_BITS:0] STEP_YE  = (Y_BITS + 1)'(STEP);
  localparam logic [Y_BITS:0] Y_MIN_E  = (Y_BITS + 1)'(Y_MIN);
  localparam logic [Y_BITS:0] Y_MAX_E  = (Y_BITS + 1)'(Y_MAX);

  typedef enum logic [2:0] {START, IDLE, ERASE, UPDATE, DRAW, DONE} state_t;

  state_t            state_q, state_d;
  logic [X_BITS-1:0] pos_x_q, pos_x_d, tgt_x_q, tgt_x_d;
  logic [Y_BITS-1:0] pos_y_q, pos_y_d, tgt_y_q, tgt_y_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;

  logic [X_BITS:0]   px_e, tx_e;
  logic [Y_BITS:0]   py_e, ty_e;
  logic              moving;
  logic              last_col, last_pix;

  assign last_col = (col_q == CW'(SPR_W - 1));
  assign last_pix = last_col && (row_q == RW'(SPR_H - 1));

  // Clamped target, one guard bit wide so neither edge can wrap around.
  always_comb begin
    px_e = {1'b0, pos_x_q};
    py_e = {1'b0, pos_y_q};
    tx_e = px_e;
    ty_e = py_e;
    if (p_right && !p_left)
      tx_e = (px_e + STEP_XE > X_MAX_E) ? X_MAX_E : px_e + STEP_XE;
    else if (p_left && !p_right)
      tx_e = (px_e < X_MIN_E + STEP_XE) ? X_MIN_E : px_e - STEP_XE;
    if (p_down && !p_up)
      ty_e = (py_e + STEP_YE > Y_MAX_E) ? Y_MAX_E : py_e + STEP_YE;
    else if (p_up && !p_down)
      ty_e = (py_e < Y_MIN_E + STEP_YE) ? Y_MIN_E : py_e - STEP_YE;
    moving = (tx_e != px_e) || (ty_e != py_e);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= START;
      pos_x_q <= X_BITS'(X_INIT);
      pos_y_q <= Y_BITS'(Y_INIT);
      tgt_x_q <= X_BITS'(X_INIT);
      tgt_y_q <= Y_BITS'(Y_INIT);
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    col_d   = '0;
    row_d   = '0;
    case (state_q)
      START: state_d = DRAW;
      IDLE: begin
        if (moving) begin
          tgt_x_d = tx_e[X_BITS-1:0];
          tgt_y_d = ty_e[Y_BITS-1:0];
          state_d = ERASE;
        end
      end
      ERASE, DRAW: begin
        if (last_pix) begin
          state_d = (state_q == ERASE) ? UPDATE : DONE;
        end else if (last_col) begin
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
          row_d = row_q;
        end
      end
      UPDATE: begin
        pos_x_d = tgt_x_q;
        pos_y_d = tgt_y_q;
        state_d = DRAW;
      end
      DONE:    state_d = IDLE;
      default: state_d = START;
    endcase
  end

  always_comb begin
    write_en = 1'b0;
    colour   = BG_COLOUR;
    x_out    = pos_x_q;
    y_out    = pos_y_q;
    if (state_q == ERASE || state_q == DRAW) begin
      write_en = 1'b1;
      colour   = (state_q == DRAW) ? FG_COLOUR : BG_COLOUR;
      x_out    = pos_x_q + X_BITS'(col_q);
      y_out    = pos_y_q + Y_BITS'(row_q);
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: a default instance (2x3, STEP 1) and a
// 4x2, STEP 3 instance; expected pixel writes are queued as moves are driven.
module tb_sprite_mover;

  typedef logic [17:0] pix_t;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  logic [3:0] req_a, req_b;

  logic [7:0] xo_a, xo_b, px_a, px_b;
  logic [6:0] yo_a, yo_b, py_a, py_b;
  logic [2:0] col_a, col_b;
  logic       we_a, we_b, busy_a, busy_b, done_a, done_b;

  pix_t q_a[$];
  pix_t q_b[$];
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  int   total = 0;
  int   bad = 0;

  int mx[2];
  int my[2];
  int sw[2] = '{2, 4};
  int sh[2] = '{3, 2};
  int st[2] = '{1, 3};

  always #5 clk = ~clk;

  sprite_mover dut_a (
    .clk(clk), .reset_n(rst_a_n),
    .p_up(req_a[3]), .p_down(req_a[2]), .p_left(req_a[1]), .p_right(req_a[0]),
    .x_out(xo_a), .y_out(yo_a), .colour(col_a), .write_en(we_a),
    .pos_x(px_a), .pos_y(py_a), .busy(busy_a), .done(done_a)
  );

  sprite_mover #(.SPR_W(4), .SPR_H(2), .STEP(3)) dut_b (
    .clk(clk), .reset_n(rst_b_n),
    .p_up(req_b[3]), .p_down(req_b[2]), .p_left(req_b[1]), .p_right(req_b[0]),
    .x_out(xo_b), .y_out(yo_b), .colour(col_b), .write_en(we_b),
    .pos_x(px_b), .pos_y(py_b), .busy(busy_b), .done(done_b)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (we_a) begin
      if (q_a.size() == 0) checkOutput("a_unexpected_write", {col_a, xo_a, yo_a}, 0);
      else begin
        e = q_a.pop_front();
        checkOutput("a_pixel", {col_a, xo_a, yo_a}, e);
      end
    end
    if (we_b) begin
      if (q_b.size() == 0) checkOutput("b_unexpected_write", {col_b, xo_b, yo_b}, 0);
      else begin
        e = q_b.pop_front();
        checkOutput("b_pixel", {col_b, xo_b, yo_b}, e);
      end
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic push_pix(input int d, input int x, input int y, input int c);
    pix_t p;
    p = {3'(c), 8'(x), 7'(y)};
    if (d == 0) q_a.push_back(p);
    else q_b.push_back(p);
  endtask

  task automatic push_rect(input int d, input int x, input int y, input int c);
    for (int r = 0; r < sh[d]; r++)
      for (int k = 0; k < sw[d]; k++)
        push_pix(d, x + k, y + r, c);
  endtask

  task automatic drive_req(input int d, input logic [3:0] r);
    if (d == 0) req_a = r;
    else req_b = r;
  endtask

  function automatic logic done_of(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction

  function automatic int done_cnt_of(input int d);
    return (d == 0) ? done_cnt_a : done_cnt_b;
  endfunction

  function automatic int qsize_of(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic check_pos(input int d, input string tag);
    checkOutput({tag, "_pos_x"}, (d == 0) ? px_a : px_b, mx[d]);
    checkOutput({tag, "_pos_y"}, (d == 0) ? py_a : py_b, my[d]);
  endtask

  // Counts negedges from the current one until done, within a budget.
  task automatic wait_done(input int d, input int exp_lat, input int pulse_at, input string tag);
    int i;
    for (i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) drive_req(d, 4'b0000);
      if (pulse_at != 0 && i == pulse_at) drive_req(d, 4'b0100);
      if (pulse_at != 0 && i == pulse_at + 1) drive_req(d, 4'b0000);
      if (done_of(d)) break;
    end
    checkOutput({tag, "_latency"}, i, exp_lat);
    @(negedge clk);
    checkOutput({tag, "_busy_after"}, busy_of(d), 0);
  endtask

  task automatic do_reset(input int d);
    if (d == 0) rst_a_n = 1'b0;
    else rst_b_n = 1'b0;
    drive_req(d, 4'b1111);
    repeat (2) @(negedge clk);
    drive_req(d, 4'b0000);
    checkOutput("rst_we", (d == 0) ? we_a : we_b, 0);
    checkOutput("rst_done", done_of(d), 0);
    checkOutput("rst_busy", busy_of(d), 1);
    checkOutput("rst_colour", (d == 0) ? col_a : col_b, 0);
    checkOutput("rst_x_out", (d == 0) ? xo_a : xo_b, 0);
    checkOutput("rst_y_out", (d == 0) ? yo_a : yo_b, 58);
    mx[d] = 0;
    my[d] = 58;
    push_rect(d, 0, 58, 7);
    if (d == 0) rst_a_n = 1'b1;
    else rst_b_n = 1'b1;
    wait_done(d, sw[d] * sh[d] + 1, 0, "init");
    checkOutput("init_queue_empty", qsize_of(d), 0);
    check_pos(d, "init");
  endtask

  // r = {up, down, left, right}; held for exactly one IDLE cycle.
  task automatic applyStimulus(input int d, input logic [3:0] r, input int pulse_at);
    int tx, ty, dc0;
    bit moved;
    tx = mx[d];
    ty = my[d];
    if (r[3] && !r[2]) ty = (my[d] - st[d] < 0) ? 0 : my[d] - st[d];
    if (r[2] && !r[3]) ty = (my[d] + st[d] > 117) ? 117 : my[d] + st[d];
    if (r[1] && !r[0]) tx = (mx[d] - st[d] < 0) ? 0 : mx[d] - st[d];
    if (r[0] && !r[1]) tx = (mx[d] + st[d] > 158) ? 158 : mx[d] + st[d];
    moved = (tx != mx[d]) || (ty != my[d]);
    dc0 = done_cnt_of(d);
    if (moved) begin
      push_rect(d, mx[d], my[d], 0);
      push_rect(d, tx, ty, 7);
    end
    drive_req(d, r);
    if (moved) begin
      wait_done(d, 2 * sw[d] * sh[d] + 2, pulse_at, "move");
      checkOutput("move_done_count", done_cnt_of(d), dc0 + 1);
    end else begin
      repeat (3) begin
        @(negedge clk);
        drive_req(d, 4'b0000);
      end
      checkOutput("nomove_busy", busy_of(d), 0);
      checkOutput("nomove_done_count", done_cnt_of(d), dc0);
    end
    mx[d] = tx;
    my[d] = ty;
    checkOutput("move_queue_empty", qsize_of(d), 0);
    check_pos(d, "move");
  endtask

  initial begin
    int dc0;
    int i;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    @(negedge clk);

    do_reset(0);
    do_reset(1);

    applyStimulus(0, 4'b1000, 0);
    applyStimulus(0, 4'b1100, 0);
    applyStimulus(0, 4'b0101, 0);
    applyStimulus(0, 4'b0100, 10);
    while (my[0] < 115) applyStimulus(0, 4'b0100, 0);

    $display("[TB] holding p_down from y=%0d", my[0]);
    dc0 = done_cnt_a;
    push_rect(0, mx[0], 115, 0);
    push_rect(0, mx[0], 116, 7);
    push_rect(0, mx[0], 116, 0);
    push_rect(0, mx[0], 117, 7);
    req_a = 4'b0100;
    for (i = 0; i < 100 && done_cnt_a < dc0 + 2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    req_a = 4'b0000;
    @(negedge clk);
    my[0] = 117;
    checkOutput("hold_done_count", done_cnt_a, dc0 + 2);
    checkOutput("hold_queue_empty", q_a.size(), 0);
    checkOutput("hold_busy", busy_a, 0);
    check_pos(0, "hold");

    // Reset on the third erase cycle of an upward move.
    for (int k = 0; k < 3; k++) push_pix(0, mx[0] + k % sw[0], my[0] + k / sw[0], 0);
    req_a = 4'b1000;
    for (i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) req_a = 4'b0000;
      if (i == 3) rst_a_n = 1'b0;
    end
    checkOutput("midrst_we", we_a, 0);
    checkOutput("midrst_busy", busy_a, 1);
    checkOutput("midrst_x_out", xo_a, 0);
    checkOutput("midrst_y_out", yo_a, 58);
    checkOutput("midrst_queue", q_a.size(), 0);
    mx[0] = 0;
    my[0] = 58;
    push_rect(0, 0, 58, 7);
    rst_a_n = 1'b1;
    wait_done(0, 7, 0, "midrst");
    check_pos(0, "midrst");

    while (my[0] > 0) applyStimulus(0, 4'b1000, 0);
    applyStimulus(0, 4'b1000, 0);
    applyStimulus(0, 4'b0010, 0);

    while (mx[1] < 156) applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0001, 0);
    checkOutput("b_clamp_x", px_b, 158);
    applyStimulus(1, 4'b0001, 0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SPR_W  2  sprite width in pixels, >=1
  SPR_H  3  sprite height in pixels, >=1
  X_BITS  8  x coordinate width
  Y_BITS  7  y coordinate width
  STEP  1  pixels moved per accepted request, >=1
  X_MIN / X_MAX  0 / 158  legal range of sprite top-left x
  Y_MIN / Y_MAX  0 / 117  legal range of sprite top-left y
  X_INIT / Y_INIT  0 / 58  top-left position after reset
  FG_COLOUR  3'b111  sprite colour
  BG_COLOUR  3'b000  erase colour
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  system clock
  reset_n  in  1  reset; synchronous and active-low; one clock
  p_up / p_down / p_left / p_right  in  1 each  move requests, level-sampled
  x_out  out  X_BITS  pixel x to the VGA adapter
  y_out  out  Y_BITS  pixel y to the VGA adapter
  colour  out  3  pixel colour
  write_en  out  1  pixel write strobe
  pos_x / pos_y  out  X_BITS / Y_BITS  current sprite top-left
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle pulse when a redraw completes

Function
REQ-003 FSM states SHALL be START, IDLE, ERASE, UPDATE, DRAW and DONE; outputs are Moore, decoded from the registered state, pixel counters and position.
REQ-004 START SHALL go to DRAW unconditionally after one cycle, with write_en=0.
REQ-005 IDLE SHALL sample the requests each cycle: net_dy = p_down - p_up and net_dx = p_right - p_left, so opposing requests cancel.
REQ-006 In IDLE the clamped target SHALL be computed as follows.
  ty = y - STEP, saturated at Y_MIN, for up; y + STEP, saturated at Y_MAX, for down.
  tx is computed the same way using X_MIN / X_MAX.
REQ-007 Arithmetic SHALL use one extra guard bit so that no wrap-around occurs.
REQ-008 If (tx, ty) equals (pos_x, pos_y), including the both-cancelled and clamped-at-edge cases, IDLE SHALL stay in IDLE with no writes; otherwise it SHALL latch (tx, ty) and go to ERASE.
REQ-009 A diagonal move, one vertical and one horizontal request, SHALL be applied in a single redraw.
REQ-010 ERASE and DRAW SHALL each scan N = SPR_W*SPR_H pixels, one per cycle, in this order.
  The column counter runs 0..SPR_W-1 as the inner loop; the row counter runs 0..SPR_H-1 as the outer loop.
  x_out = pos_x + col, y_out = pos_y + row, write_en = 1.
REQ-011 ERASE SHALL output colour BG_COLOUR at the old position, and DRAW SHALL output FG_COLOUR at the current position.
REQ-012 After the last pixel (col=SPR_W-1, row=SPR_H-1), ERASE SHALL go to UPDATE and DRAW SHALL go to DONE, with both counters cleared to 0.
REQ-013 UPDATE SHALL copy the latched target into pos_x/pos_y, hold write_en=0 and go to DRAW.
REQ-014 DONE SHALL assert done=1 and write_en=0 for one cycle, then go to IDLE.
REQ-015 Move latency SHALL be fixed: from the IDLE cycle that accepts a move, the block is busy for exactly 2N+2 further cycles before returning to IDLE.
REQ-016 Requests SHALL be ignored whenever busy=1; they are never queued, and a request still held is re-sampled at IDLE.
REQ-017 Outside ERASE and DRAW, the outputs SHALL be write_en=0, colour=BG_COLOUR, x_out=pos_x and y_out=pos_y.
REQ-018 Up SHALL mean decreasing y, following VGA raster convention.

Reset
REQ-019 When reset_n=0 at a clk edge, the block SHALL load the following, regardless of the current state or any requests.
  state=START, pos_x=X_INIT, pos_y=Y_INIT, counters=0, latched target=(X_INIT,Y_INIT).
REQ-020 The outputs after the reset edge SHALL be write_en=0, done=0, busy=1, colour=BG_COLOUR, x_out=X_INIT and y_out=Y_INIT.
REQ-021 Reset mid-ERASE or mid-DRAW SHALL abandon the scan immediately, with no further writes until DRAW after START, and no erase of partially drawn pixels.

Verification
REQ-022 Defaults SHALL be used unless stated otherwise, giving N=6; the bench SHALL cover the following scenarios.
  Reset, then idle: START for 1 cycle; DRAW writes (0,58),(1,58),(0,59),(1,59),(0,60),(1,60) in colour 7; done pulses; busy=0.
  p_up held for 1 IDLE cycle at y=58: erase 6 pixels at y=58..60 in colour 0; UPDATE; draw at y=57..59; done exactly 14 cycles after the accepting cycle.
  p_up and p_down together, or p_up at y=Y_MIN: no write_en, stays IDLE, pos unchanged.
  p_down held continuously from y=115 with STEP=1: moves to 116, then 117, then stays at 117 with no further redraws.
  p_down pulsed during DRAW: ignored, no extra move; p_right+p_down together: single redraw at (x+1, y+1).
  reset_n=0 on the 3rd ERASE cycle after a move: pos returns to (0,58), START then DRAW at the initial position.
  SPR_W=4, SPR_H=2, STEP=3: move right from x=156 clamps to 158; scan order covers 8 pixels row-major.
